// File: rtl/sim_frame_gen.sv
// sim_frame_gen: framed test-packet generator for link simulation.
// Frame = SYNC, FRAME#, FRAME_LEN x CH_NUM samples (channel-interleaved), CHK.
// Words stream over a valid/ready interface; triggers come from an internal
// period tick or from the rising edge of iSTART, with a one-deep pending slot.
module sim_frame_gen #(
    parameter int          DATA_W    = 16,
    parameter int          CH_NUM    = 2,
    parameter int          FRAME_LEN = 32,
    parameter int          PERIOD    = 50000000,
    parameter logic [15:0] SYNC_WORD = 16'hA5C3
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iPERIODIC,
    input  logic              iSTART,
    input  logic [1:0]        iMODE,
    input  logic [DATA_W-1:0] iCONST,
    input  logic              iREADY,
    output logic [DATA_W-1:0] oDATA,
    output logic              oVALID,
    output logic              oSOF,
    output logic              oEOF,
    output logic              oBUSY,
    output logic [15:0]       oFRAME_CNT,
    output logic [7:0]        oMISSED
);

    localparam int PER_W  = $clog2(PERIOD);
    localparam int SLOT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_COUNT = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_TAG   = 2'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        NUM,
        DATA,
        CHK
    } stateT;

    stateT              state;
    stateT              nextState;

    logic [PER_W-1:0]   perCnt;
    logic               perTick;
    logic               startQ;
    logic               tick;
    logic               pending;
    logic [7:0]         missed;
    logic [15:0]        frameCnt;

    logic [1:0]         modeQ;
    logic [DATA_W-1:0]  constQ;
    logic [SLOT_W-1:0]  slotIdx;
    logic [3:0]         chIdx;
    logic               lastCh;
    logic               lastSlot;
    logic [DATA_W-1:0]  sampleCnt;
    logic [15:0]        lfsr;
    logic [DATA_W-1:0]  chkAcc;

    logic               busy;
    logic               frameStart;
    logic               xfer;
    logic [DATA_W-1:0]  frameWord;
    logic [DATA_W-1:0]  slotExt;
    logic [DATA_W-1:0]  tagWord;
    logic [DATA_W-1:0]  sampleWord;

    assign busy       = (state != IDLE);
    assign perTick    = (perCnt == PER_W'(PERIOD - 1));
    assign tick       = iPERIODIC ? perTick : (iSTART & ~startQ);
    assign frameStart = (state == IDLE) && (tick || pending);
    assign xfer       = oVALID & iREADY;
    assign lastCh     = (chIdx == 4'(CH_NUM - 1));
    assign lastSlot   = (slotIdx == SLOT_W'(FRAME_LEN - 1));
    assign frameWord  = DATA_W'(frameCnt);
    assign slotExt    = DATA_W'(slotIdx);

    assign oFRAME_CNT = frameCnt;
    assign oMISSED    = missed;

    // Channel-tagged sample: channel in the top nibble, slot below it.
    always_comb begin
        tagWord                  = '0;
        tagWord[DATA_W-1 -: 4]   = chIdx;
        tagWord[DATA_W-5:0]      = slotExt[DATA_W-5:0];
    end

    // Sample value for the word currently presented, from the captured mode.
    always_comb begin
        sampleWord = '0;
        case (modeQ)
            MODE_CONST: sampleWord = constQ;
            MODE_COUNT: sampleWord = sampleCnt;
            MODE_LFSR:  sampleWord = DATA_W'(lfsr);
            MODE_TAG:   sampleWord = tagWord;
            default:    sampleWord = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge iclk) begin
        if (!ireset) state <= IDLE;
        else         state <= nextState;
    end

    // Next-state and stream outputs; every non-idle state presents one word.
    always_comb begin
        nextState = state;
        oVALID    = 1'b0;
        oSOF      = 1'b0;
        oEOF      = 1'b0;
        oBUSY     = 1'b0;
        oDATA     = '0;
        case (state)
            IDLE: begin
                if (tick || pending) nextState = SYNC;
            end
            SYNC: begin
                oVALID = 1'b1;
                oBUSY  = 1'b1;
                oSOF   = 1'b1;
                oDATA  = DATA_W'(SYNC_WORD);
                if (iREADY) nextState = NUM;
            end
            NUM: begin
                oVALID = 1'b1;
                oBUSY  = 1'b1;
                oDATA  = frameWord;
                if (iREADY) nextState = DATA;
            end
            DATA: begin
                oVALID = 1'b1;
                oBUSY  = 1'b1;
                oDATA  = sampleWord;
                if (iREADY && lastCh && lastSlot) nextState = CHK;
            end
            CHK: begin
                oVALID = 1'b1;
                oBUSY  = 1'b1;
                oEOF   = 1'b1;
                oDATA  = chkAcc;
                if (iREADY) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Free-running period counter and iSTART edge register.
    always_ff @(posedge iclk) begin
        if (!ireset) begin
            perCnt <= '0;
            startQ <= 1'b0;
        end else begin
            perCnt <= perTick ? '0 : perCnt + 1'b1;
            startQ <= iSTART;
        end
    end

    // One-deep pending slot; a tick that finds it full is counted as missed.
    always_ff @(posedge iclk) begin
        if (!ireset) begin
            pending <= 1'b0;
            missed  <= '0;
        end else if (frameStart) begin
            pending <= 1'b0;
        end else if (tick && busy) begin
            if (!pending)             pending <= 1'b1;
            else if (missed != 8'hFF) missed  <= missed + 1'b1;
        end
    end

    // Source selection is frozen for the whole frame at frame start.
    always_ff @(posedge iclk) begin
        if (!ireset) begin
            modeQ  <= '0;
            constQ <= '0;
        end else if (frameStart) begin
            modeQ  <= iMODE;
            constQ <= iCONST;
        end
    end

    // Slot/channel position inside the sample block, advanced per sample transfer.
    always_ff @(posedge iclk) begin
        if (!ireset || frameStart) begin
            slotIdx <= '0;
            chIdx   <= '0;
        end else if (xfer && state == DATA) begin
            if (lastCh) begin
                chIdx   <= '0;
                slotIdx <= lastSlot ? '0 : slotIdx + 1'b1;
            end else begin
                chIdx   <= chIdx + 1'b1;
            end
        end
    end

    // Counter and LFSR sources persist across frames; each steps only while
    // it is the active source, so switching modes does not disturb the other.
    always_ff @(posedge iclk) begin
        if (!ireset) begin
            sampleCnt <= '0;
            lfsr      <= LFSR_SEED;
        end else if (xfer && state == DATA) begin
            if (modeQ == MODE_COUNT) sampleCnt <= sampleCnt + 1'b1;
            if (modeQ == MODE_LFSR)  lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
        end
    end

    // Running checksum over FRAME# and samples; SYNC is not included.
    always_ff @(posedge iclk) begin
        if (!ireset || frameStart) begin
            chkAcc <= '0;
        end else if (xfer && state == NUM) begin
            chkAcc <= chkAcc ^ frameWord;
        end else if (xfer && state == DATA) begin
            chkAcc <= chkAcc ^ sampleWord;
        end
    end

    // Completed-frame counter, bumped when the checksum word is accepted.
    always_ff @(posedge iclk) begin
        if (!ireset)                    frameCnt <= '0;
        else if (xfer && state == CHK)  frameCnt <= frameCnt + 1'b1;
    end

endmodule
